// File: rtl/dtc_preimage_search.sv
// rtl/dtc_preimage_search.sv - upward preimage search driving a combinational decision-tree classifier.
// Optional abort input enabled by defining DTC_SEARCH_ABORT_EN.
module dtc_preimage_search #(
    parameter int IN_W  = 12,
    parameter int CLS_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CLS_W-1:0] req_class,
    input  logic [IN_W-1:0]  req_start,
    output logic [IN_W-1:0]  cand,
    input  logic [CLS_W-1:0] cand_class,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_found,
    output logic [IN_W-1:0]  rsp_vec,
`ifdef DTC_SEARCH_ABORT_EN
    input  logic             abort,
`endif
    output logic [IN_W:0]    rsp_count
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;

    localparam logic [IN_W:0] CNT_MAX = {1'b1, {IN_W{1'b0}}};

    state_t           r_state;
    state_t           w_next;
    logic [IN_W-1:0]  r_cand;
    logic [CLS_W-1:0] r_target;
    logic [IN_W:0]    r_cnt;
    logic             r_found;
    logic [IN_W-1:0]  r_vec;
    logic [IN_W:0]    r_count;
    logic             w_accept;
    logic             w_match;
    logic             w_stop;
    logic             w_abort;

`ifdef DTC_SEARCH_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_match  = 1'b0;
        w_stop   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = req_valid;
                if (req_valid) begin
                    w_next = S_SCAN;
                end
            end
            S_SCAN: begin
                // A match this cycle outranks both exhaustion and abort.
                w_match = (cand_class == r_target);
                w_stop  = (r_cnt == CNT_MAX) || w_abort;
                if (w_match || w_stop) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand   <= '0;
            r_target <= '0;
            r_cnt    <= '0;
            r_found  <= 1'b0;
            r_vec    <= '0;
            r_count  <= '0;
        end else if (w_accept) begin
            r_cand   <= req_start;
            r_target <= req_class;
            r_cnt    <= {{IN_W{1'b0}}, 1'b1};
        end else if (r_state == S_SCAN) begin
            if (w_match || w_stop) begin
                r_found <= w_match;
                r_vec   <= r_cand;
                r_count <= r_cnt;
            end else begin
                r_cand <= r_cand + 1'b1;
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign cand      = r_cand;
    assign rsp_found = r_found;
    assign rsp_vec   = r_vec;
    assign rsp_count = r_count;

endmodule

// File: tb/tb_dtc_preimage_search.sv
// tb/tb_dtc_preimage_search.sv - directed vector bench for dtc_preimage_search with a modelled classifier.
module tb_dtc_preimage_search;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_class = '0;
    logic [11:0] req_start = '0;
    logic [11:0] cand;
    logic [2:0]  cand_class;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_found;
    logic [11:0] rsp_vec;
    logic [12:0] rsp_count;
`ifdef DTC_SEARCH_ABORT_EN
    logic        abort = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    int mode = 0;

    always #5 clk = ~clk;

    // Classifier models: 0 -> low three bits, 1 -> constant 7, 2 -> class 2 only at 0x001.
    always_comb begin
        cand_class = 3'd0;
        case (mode)
            0: cand_class = cand[2:0];
            1: cand_class = 3'd7;
            2: cand_class = (cand == 12'h001) ? 3'd2 : 3'd0;
            default: cand_class = 3'd0;
        endcase
    end

    dtc_preimage_search dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_class  (req_class),
        .req_start  (req_start),
        .cand       (cand),
        .cand_class (cand_class),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_found  (rsp_found),
        .rsp_vec    (rsp_vec),
`ifdef DTC_SEARCH_ABORT_EN
        .abort      (abort),
`endif
        .rsp_count  (rsp_count)
    );

    typedef struct {
        int          mode;
        logic [2:0]  cls;
        logic [11:0] start;
        logic        found;
        logic [11:0] vec;
        int          count;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Issue one request and wait for rsp_valid; lat is edges after acceptance.
    task automatic do_search(input int m, input logic [2:0] cls, input logic [11:0] st, output int lat);
        mode = m;
        @(negedge clk);
        req_class = cls;
        req_start = st;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_class = ~cls;
        lat = 0;
        while (!rsp_valid && lat < 5000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_rsp(input string name);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({name, "_rsp_valid_drop"}, int'(rsp_valid), 0);
        check({name, "_req_ready_back"}, int'(req_ready), 1);
    endtask

    initial begin
        int lat;
        int seen;
        logic [11:0] hold_vec;
        logic [12:0] hold_cnt;

        tbl[0] = '{0, 3'd5, 12'h000, 1'b1, 12'h005, 6};
        tbl[1] = '{1, 3'd0, 12'h800, 1'b0, 12'h7FF, 4096};
        tbl[2] = '{2, 3'd2, 12'hFFE, 1'b1, 12'h001, 4};
        tbl[3] = '{0, 3'd3, 12'h003, 1'b1, 12'h003, 1};
        tbl[4] = '{0, 3'd0, 12'h7F9, 1'b1, 12'h800, 8};
        tbl[5] = '{2, 3'd2, 12'h001, 1'b1, 12'h001, 1};
        tbl[6] = '{1, 3'd7, 12'hABC, 1'b1, 12'hABC, 1};

        #12;
        check("reset_cand", int'(cand), 0);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_found", int'(rsp_found), 0);
        check("reset_rsp_vec", int'(rsp_vec), 0);
        check("reset_rsp_count", int'(rsp_count), 0);
        check("reset_req_ready", int'(req_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_search(tbl[i].mode, tbl[i].cls, tbl[i].start, lat);
            check($sformatf("v%0d_latency", i), lat, tbl[i].count);
            check($sformatf("v%0d_found", i), int'(rsp_found), int'(tbl[i].found));
            check($sformatf("v%0d_vec", i), int'(rsp_vec), int'(tbl[i].vec));
            check($sformatf("v%0d_count", i), int'(rsp_count), tbl[i].count);
            check($sformatf("v%0d_req_ready_low", i), int'(req_ready), 0);
            finish_rsp($sformatf("v%0d", i));
        end

        // Backpressure: response held for 10 cycles while a new request is offered.
        do_search(0, 3'd5, 12'h000, lat);
        check("bp_latency", lat, 6);
        hold_vec = rsp_vec;
        hold_cnt = rsp_count;
        for (int c = 0; c < 10; c++) begin
            req_valid = (c == 3 || c == 4);
            req_start = 12'h123;
            req_class = 3'd3;
            @(posedge clk);
            #1;
            if (c == 9) begin
                check("bp_rsp_valid", int'(rsp_valid), 1);
                check("bp_req_ready", int'(req_ready), 0);
                check("bp_found", int'(rsp_found), 1);
                check("bp_vec", int'(rsp_vec), int'(hold_vec));
                check("bp_count", int'(rsp_count), int'(hold_cnt));
                check("bp_cand", int'(cand), 12'h005);
            end else if (!rsp_valid || req_ready || rsp_vec != 12'h005 || rsp_count != 13'd6) begin
                check($sformatf("bp_stable_c%0d", c), 0, 1);
            end
        end
        req_valid = 1'b0;
        finish_rsp("bp");
        check("bp_no_accept_cand", int'(cand), 12'h005);

        // Reset in the middle of a search at cnt=100.
        do_search(1, 3'd0, 12'h000, lat);
        check("rst_prefix_running", int'(rsp_valid), 1);
        finish_rsp("rst_prefix");
        mode = 1;
        @(negedge clk);
        req_class = 3'd0;
        req_start = 12'h000;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        check("rst_mid_cand_before", int'(cand), 99);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cand", int'(cand), 0);
        check("rst_mid_rsp_valid", int'(rsp_valid), 0);
        check("rst_mid_req_ready", int'(req_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 4200; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        check("rst_no_response", seen, 0);
        check("rst_idle_ready", int'(req_ready), 1);

`ifdef DTC_SEARCH_ABORT_EN
        mode = 1;
        @(negedge clk);
        req_class = 3'd1;
        req_start = 12'h000;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_rsp_valid", int'(rsp_valid), 1);
        check("abort_found", int'(rsp_found), 0);
        check("abort_vec", int'(rsp_vec), 12'h031);
        check("abort_count", int'(rsp_count), 50);
        finish_rsp("abort");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
